// File: rtl/multdiv_issue.sv
// Issue controller for the iterative multiply/divide units: latches operands,
// pulses the unit start, stalls until ready or timeout, then emits one writeback.
module multdiv_issue #(
    parameter int TIMEOUT       = 40,
    parameter int MULT_EXC_CODE = 4,
    parameter int DIV_EXC_CODE  = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_isDiv,
    input  logic [31:0] issue_A,
    input  logic [31:0] issue_B,
    input  logic [4:0]  issue_rd,
    input  logic        flush,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [4:0] EXC_RD = 5'd30;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          is_div;
    logic [4:0]    rd_q;

    logic          accept;
    logic          timed_out;
    logic [31:0]   exc_code;

    assign accept    = issue_valid & ~flush;
    assign timed_out = (count == CW'(TIMEOUT - 1));
    assign exc_code  = is_div ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE);

    always_comb begin
        stall = 1'b0;
        unique case (state)
            IDLE:  stall = accept;
            START: stall = 1'b1;
            WAIT:  stall = 1'b1;
            DONE:  stall = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            count       <= '0;
            is_div      <= 1'b0;
            rd_q        <= '0;
            md_operandA <= '0;
            md_operandB <= '0;
            ctrl_MULT   <= 1'b0;
            ctrl_DIV    <= 1'b0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
        end else begin
            ctrl_MULT <= 1'b0;
            ctrl_DIV  <= 1'b0;
            wb_valid  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        md_operandA <= issue_A;
                        md_operandB <= issue_B;
                        rd_q        <= issue_rd;
                        is_div      <= issue_isDiv;
                        ctrl_DIV    <= issue_isDiv;
                        ctrl_MULT   <= ~issue_isDiv;
                        state       <= START;
                    end
                end
                START: begin
                    // ready here may be left over from the previous op
                    count <= '0;
                    state <= flush ? IDLE : WAIT;
                end
                WAIT: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (md_resultRDY) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= md_exception ? EXC_RD : rd_q;
                        wb_data  <= md_exception ? exc_code : md_result;
                        state    <= DONE;
                    end else if (timed_out) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= EXC_RD;
                        wb_data  <= exc_code;
                        state    <= DONE;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_issue.sv
// Directed bench for multdiv_issue: cycle-accurate checks of pulse, stall,
// writeback timing, exception codes, flush, timeout and asynchronous reset.
module tb_multdiv_issue;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_isDiv = 1'b0;
    logic [31:0] issue_A = '0;
    logic [31:0] issue_B = '0;
    logic [4:0]  issue_rd = '0;
    logic        flush = 1'b0;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic [31:0] md_result = '0;
    logic        md_exception = 1'b0;
    logic        md_resultRDY = 1'b0;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int total = 0;
    int bad = 0;

    multdiv_issue #(
        .TIMEOUT(40),
        .MULT_EXC_CODE(4),
        .DIV_EXC_CODE(5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .issue_valid(issue_valid),
        .issue_isDiv(issue_isDiv),
        .issue_A(issue_A),
        .issue_B(issue_B),
        .issue_rd(issue_rd),
        .flush(flush),
        .ctrl_MULT(ctrl_MULT),
        .ctrl_DIV(ctrl_DIV),
        .md_operandA(md_operandA),
        .md_operandB(md_operandB),
        .md_result(md_result),
        .md_exception(md_exception),
        .md_resultRDY(md_resultRDY),
        .stall(stall),
        .wb_valid(wb_valid),
        .wb_rd(wb_rd),
        .wb_data(wb_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    // Caller is at the start of T0; ready is raised in cycle rdy_t (0 = never).
    task automatic run_op(input string tag, input logic dv,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int rdy_t,
                          input logic exc, input logic [31:0] res,
                          input logic stale, input int exp_t,
                          input logic [4:0] exp_rd,
                          input logic [31:0] exp_data);
        int t, done_t, n_div, n_mult, pulse_t, stall_lo, op_bad;
        logic [4:0]  got_rd;
        logic [31:0] got_data;
        logic        got_stall;
        t = 0; done_t = 0; n_div = 0; n_mult = 0; pulse_t = 0;
        stall_lo = 0; op_bad = 0;
        got_rd = '0; got_data = '0; got_stall = 1'b1;
        issue_valid = 1'b1;
        issue_isDiv = dv;
        issue_A = a;
        issue_B = b;
        issue_rd = rd;
        #1;
        chk({tag, ".t0_stall"}, 32'(stall), 32'd1);
        while (t < 60 && done_t == 0) begin
            next();
            t++;
            issue_valid = 1'b0;
            issue_isDiv = ~dv;
            issue_A = ~a;
            issue_B = ~b;
            issue_rd = ~rd;
            md_resultRDY = (t == rdy_t) || (stale && t == 1);
            md_result = (t == rdy_t) ? res : 32'hBAD0BAD0;
            md_exception = (t == rdy_t) ? exc : 1'b0;
            #1;
            if (ctrl_DIV) begin n_div++; pulse_t = t; end
            if (ctrl_MULT) begin n_mult++; pulse_t = t; end
            if (md_operandA !== a || md_operandB !== b) op_bad++;
            if (wb_valid) begin
                done_t = t;
                got_rd = wb_rd;
                got_data = wb_data;
                got_stall = stall;
            end else if (!stall) begin
                stall_lo++;
            end
        end
        md_resultRDY = 1'b0;
        md_exception = 1'b0;
        chk({tag, ".done_cycle"}, 32'(done_t), 32'(exp_t));
        chk({tag, ".wb_rd"}, 32'(got_rd), 32'(exp_rd));
        chk({tag, ".wb_data"}, got_data, exp_data);
        chk({tag, ".done_stall"}, 32'(got_stall), 32'd0);
        chk({tag, ".n_div"}, 32'(n_div), dv ? 32'd1 : 32'd0);
        chk({tag, ".n_mult"}, 32'(n_mult), dv ? 32'd0 : 32'd1);
        chk({tag, ".pulse_cycle"}, 32'(pulse_t), 32'd1);
        chk({tag, ".stall_gaps"}, 32'(stall_lo), 32'd0);
        chk({tag, ".operand_drift"}, 32'(op_bad), 32'd0);
        next();
        chk({tag, ".wb_one_cycle"}, 32'(wb_valid), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
        chk("rst.opA", md_operandA, 32'd0);
        chk("rst.opB", md_operandB, 32'd0);
        chk("rst.wb_valid", 32'(wb_valid), 32'd0);
        chk("rst.wb_rd", 32'(wb_rd), 32'd0);
        chk("rst.wb_data", wb_data, 32'd0);
        reset = 1'b1;
        next();

        run_op("div", 1'b1, 32'd100, 32'd7, 5'd5, 34, 1'b0, 32'd14,
               1'b0, 35, 5'd5, 32'd14);
        run_op("div0", 1'b1, 32'd9, 32'd0, 5'd6, 34, 1'b1, 32'd0,
               1'b0, 35, 5'd30, 32'd5);
        run_op("mulovf", 1'b0, 32'h40000000, 32'd4, 5'd8, 3, 1'b1, 32'd0,
               1'b0, 4, 5'd30, 32'd4);
        run_op("mul", 1'b0, 32'd6, 32'd7, 5'd3, 2, 1'b0, 32'd42,
               1'b0, 3, 5'd3, 32'd42);
        run_op("stale", 1'b0, 32'd2, 32'd9, 5'd12, 5, 1'b0, 32'd18,
               1'b1, 6, 5'd12, 32'd18);
        run_op("tmo", 1'b1, 32'd1, 32'd1, 5'd4, 0, 1'b0, 32'd0,
               1'b0, 42, 5'd30, 32'd5);
        run_op("rd0", 1'b0, 32'd1, 32'd1, 5'd0, 2, 1'b0, 32'd1,
               1'b0, 3, 5'd0, 32'd1);

        // Flush while waiting: T10 flush, T11 idle, new issue at T12.
        issue_valid = 1'b1; issue_isDiv = 1'b0;
        issue_A = 32'd11; issue_B = 32'd13; issue_rd = 5'd7;
        for (int t = 1; t <= 10; t++) begin
            next();
            issue_valid = 1'b0;
            flush = (t == 10);
        end
        #1;
        chk("flw.t10_stall", 32'(stall), 32'd1);
        next();
        flush = 1'b0;
        md_resultRDY = 1'b1;
        md_result = 32'd143;
        #1;
        chk("flw.t11_stall", 32'(stall), 32'd0);
        chk("flw.t11_wb", 32'(wb_valid), 32'd0);
        next();
        md_resultRDY = 1'b0;
        chk("flw.t12_wb", 32'(wb_valid), 32'd0);
        run_op("postflush", 1'b1, 32'd50, 32'd5, 5'd9, 3, 1'b0, 32'd10,
               1'b0, 4, 5'd9, 32'd10);

        // Flush during the start cycle: pulse still fires, nothing commits.
        issue_valid = 1'b1; issue_isDiv = 1'b1;
        issue_A = 32'd77; issue_B = 32'd7; issue_rd = 5'd2;
        next();
        issue_valid = 1'b0;
        flush = 1'b1;
        #1;
        chk("fls.pulse", 32'(ctrl_DIV), 32'd1);
        next();
        flush = 1'b0;
        md_resultRDY = 1'b1;
        md_result = 32'd11;
        #1;
        chk("fls.stall", 32'(stall), 32'd0);
        next();
        md_resultRDY = 1'b0;
        chk("fls.wb", 32'(wb_valid), 32'd0);
        next();

        // Asynchronous reset in the middle of a wait.
        issue_valid = 1'b1; issue_isDiv = 1'b1;
        issue_A = 32'd123; issue_B = 32'd3; issue_rd = 5'd13;
        for (int t = 1; t <= 15; t++) begin
            next();
            issue_valid = 1'b0;
        end
        reset = 1'b0;
        #1;
        chk("mrst.stall", 32'(stall), 32'd0);
        chk("mrst.ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
        chk("mrst.opA", md_operandA, 32'd0);
        chk("mrst.opB", md_operandB, 32'd0);
        chk("mrst.wb_valid", 32'(wb_valid), 32'd0);
        chk("mrst.wb_rd", 32'(wb_rd), 32'd0);
        chk("mrst.wb_data", wb_data, 32'd0);
        next();
        reset = 1'b1;
        next();
        run_op("postrst", 1'b0, 32'd3, 32'd5, 5'd11, 4, 1'b0, 32'd15,
               1'b0, 5, 5'd11, 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multdiv_issue.md
# multdiv_issue

Initiator-side controller for the iterative multiply/divide units in the execute stage. Accepts one decoded mult/div instruction, holds its operands stable, pulses the unit's start control for one cycle, and stalls the pipeline until the unit reports ready. It then emits a single-cycle writeback, redirecting to `$r30` with a status code on exception or timeout. It is the issuing counterpart of the `ctrl_MULT`/`ctrl_DIV` → `data_resultRDY` handshake.

## Interface

**Parameters**
- `TIMEOUT`, default 40: maximum WAIT cycles before forcing completion.
- `MULT_EXC_CODE`, default 4: value written to `$r30` on mult exception.
- `DIV_EXC_CODE`, default 5: value written to `$r30` on div exception.

**Ports**
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; 0 = in reset.
- `issue_valid`  in  1  execute stage holds a mult/div instruction.
- `issue_isDiv`  in  1  1 = divide, 0 = multiply.
- `issue_A`, `issue_B`  in  32  source operands.
- `issue_rd`  in  5  destination register.
- `flush`  in  1  squash the in-flight or issuing instruction.
- `ctrl_MULT`, `ctrl_DIV`  out  1  one-cycle start pulses to the units.
- `md_operandA`, `md_operandB`  out  32  latched operands, stable for the whole operation.
- `md_result`  in  32  result from the selected unit.
- `md_exception`  in  1  exception from the selected unit.
- `md_resultRDY`  in  1  ready from the selected unit.
- `stall`  out  1  freeze fetch/decode/execute.
- `wb_valid`  out  1  one-cycle writeback strobe.
- `wb_rd`  out  5  writeback destination.
- `wb_data`  out  32  writeback value.

## Operation

- **States:** IDLE, START, WAIT, DONE. Reset value is IDLE.
- **Reset values:** all registered outputs and latches clear to 0, including operands, `wb_*`, and the counter.
- **IDLE**
  - `issue_valid & !flush`: latch A, B, rd and isDiv, then go to START.
  - `stall = issue_valid & !flush` (combinational).
- **START**
  - Assert `ctrl_DIV` if isDiv, else `ctrl_MULT`. Exactly one pulse per issue.
  - `stall = 1`. Clear the counter, then go to WAIT.
  - `md_resultRDY` is ignored in this cycle, because the unit may show a stale ready.
  - `flush` returns to IDLE. The pulse still occurs and the result is discarded.
- **WAIT**
  - `stall = 1`; the counter increments each cycle.
  - Priority is `flush` > ready > timeout.
  - `flush` goes to IDLE with no writeback.
  - `md_resultRDY` captures `md_result`/`md_exception` and goes to DONE.
  - Counter reaching `TIMEOUT - 1` without ready forces exception = 1 and goes to DONE.
- **DONE**
  - `stall = 0`, `wb_valid = 1` for exactly this cycle, then go to IDLE.
  - No exception: `wb_rd = rd`, `wb_data = result`.
  - Exception: `wb_rd = 30`, `wb_data = isDiv ? DIV_EXC_CODE : MULT_EXC_CODE`.
  - `flush` in DONE is ignored, because the instruction has already committed.
  - New issues are not accepted in DONE. The next instruction is sampled in IDLE.
- `md_operandA`/`md_operandB` change only on an IDLE→START transition. The units read operands combinationally every cycle.
- `rd = 0` with no exception produces `wb_valid = 1` with `wb_rd = 0`. The register file discards the write.

## Timing

- **Issue cycle (T0):** IDLE with `issue_valid`; `stall` high combinationally.
- **T1:** START; start pulse high.
- **T2 onward:** WAIT.
- Ready seen at T(2+k) → DONE at T(3+k), with `wb_valid` and `stall = 0`.
- **Minimum occupancy:** 4 cycles, T0 through DONE. For a divider ready 33 cycles after its pulse, DONE falls on T35.
- **Timeout:** DONE falls at T(2+TIMEOUT).
- Asynchronous reset at any time forces IDLE immediately. Outputs go to 0 and a pending writeback is lost.

## Test plan

1. **Divide.** Issue div A=100, B=7, rd=5; the responder model raises ready 33 cycles after `ctrl_DIV`.
   - One `ctrl_DIV` pulse at T1 and zero `ctrl_MULT`.
   - `stall` high T0–T34.
   - `wb_valid` at T35 with rd=5, data=14.
   - Operands are unchanged throughout.
2. **Divide by zero.** Div B=0; responder returns exception → `wb_rd = 30`, `wb_data = 5`.
3. **Multiply overflow.** Mult 0x40000000 × 4 with responder exception → `wb_rd = 30`, `wb_data = 4`. A non-overflow mult 6 × 7, rd=3 → `wb_rd = 3`, `wb_data = 42`.
4. **Flush.** `flush` at T10 in WAIT → no `wb_valid`, `stall` low at T11. A new issue at T12 completes normally with fresh operands.
5. **Stale ready and timeout.**
   - `md_resultRDY` held high during START → ignored, capture occurs in WAIT.
   - A responder that never asserts ready → `wb_valid` at T42 (`TIMEOUT = 40`) with the exception code.
6. **Reset mid-operation.** Reset low at T15 → all outputs 0 immediately. After release, a fresh issue gives a correct single pulse and writeback.
